// File: rtl/neuron_input_sequencer_if.sv
// Handshake bundle between the (x, w) pair sequencer and its producer/consumer.
// master drives buffer writes, start and out_ready; slave is the sequencer.
interface neuron_input_sequencer_if #(
   parameter int N_INPUTS = 3,
   parameter int DATA_W   = 8
);
   localparam int AW = $clog2(N_INPUTS) + 1;

   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DATA_W-1:0] wr_x;
   logic [DATA_W-1:0] wr_w;
   logic              start;
   logic [DATA_W-1:0] bias_in;
   logic              out_ready;
   logic [DATA_W-1:0] x_out;
   logic [DATA_W-1:0] w_out;
   logic              out_valid;
   logic              out_last;
   logic              acc_clear;
   logic [DATA_W-1:0] bias_out;
   logic              busy;
   logic              done;

   modport master (
      output wr_en, wr_addr, wr_x, wr_w, start, bias_in, out_ready,
      input  x_out, w_out, out_valid, out_last, acc_clear, bias_out, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_x, wr_w, start, bias_in, out_ready,
      output x_out, w_out, out_valid, out_last, acc_clear, bias_out, busy, done
   );
endinterface

// File: rtl/neuron_input_sequencer.sv
// Buffers N_INPUTS (x, w) pairs and streams them, with an accumulator clear
// before each pass, to the neuron MAC pipeline. All outputs come from flops.
module neuron_input_sequencer #(
   parameter int N_INPUTS = 3,
   parameter int DATA_W   = 8
) (
   input logic                     clk,
   input logic                     rst,
   neuron_input_sequencer_if.slave bus
);
   localparam int AW = $clog2(N_INPUTS) + 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CLEAR  = 2'd1;
   localparam logic [1:0] S_STREAM = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]        state_r, state_s;
   logic [AW-1:0]     index_r, index_s;
   logic [DATA_W-1:0] buf_x_r [N_INPUTS];
   logic [DATA_W-1:0] buf_w_r [N_INPUTS];
   logic [DATA_W-1:0] x_out_r, x_out_s;
   logic [DATA_W-1:0] w_out_r, w_out_s;
   logic [DATA_W-1:0] bias_r, bias_s;
   logic              valid_r, valid_s;
   logic              last_r, last_s;
   logic              clear_r, clear_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic [AW-1:0]     rd_idx_s;
   logic [DATA_W-1:0] rd_x_s, rd_w_s;
   logic              wr_hit_s;
   logic              is_last_s;

   // Entry presented next: entry 0 when leaving CLEAR, otherwise the one after index
   always_comb begin
      rd_idx_s = (state_r == S_CLEAR) ? {AW{1'b0}} : index_r + AW'(1);
      rd_x_s   = {DATA_W{1'b0}};
      rd_w_s   = {DATA_W{1'b0}};
      for (int i = 0; i < N_INPUTS; i++) begin
         rd_x_s = (rd_idx_s == AW'(i)) ? buf_x_r[i] : rd_x_s;
         rd_w_s = (rd_idx_s == AW'(i)) ? buf_w_r[i] : rd_w_s;
      end
   end

   // Buffer writes are only honoured while no pass is reading the buffer
   always_comb begin
      wr_hit_s  = bus.wr_en && ((state_r == S_IDLE) || (state_r == S_DONE)) &&
                  (bus.wr_addr < AW'(N_INPUTS));
      is_last_s = (index_r == AW'(N_INPUTS - 1));
   end

   // Next-state and next-output decode for the pass sequencer
   always_comb begin
      state_s = state_r;
      index_s = index_r;
      x_out_s = x_out_r;
      w_out_s = w_out_r;
      last_s  = last_r;
      bias_s  = bias_r;
      valid_s = 1'b0;
      clear_s = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (bus.start) begin
               state_s = S_CLEAR;
               index_s = {AW{1'b0}};
               bias_s  = bus.bias_in;
               clear_s = 1'b1;
               busy_s  = 1'b1;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_CLEAR: begin
            state_s = S_STREAM;
            index_s = {AW{1'b0}};
            x_out_s = rd_x_s;
            w_out_s = rd_w_s;
            last_s  = (rd_idx_s == AW'(N_INPUTS - 1));
            valid_s = 1'b1;
            busy_s  = 1'b1;
         end
         S_STREAM: begin
            if (bus.out_ready && is_last_s) begin
               state_s = S_DONE;
               x_out_s = {DATA_W{1'b0}};
               w_out_s = {DATA_W{1'b0}};
               last_s  = 1'b0;
               done_s  = 1'b1;
            end else if (bus.out_ready) begin
               index_s = rd_idx_s;
               x_out_s = rd_x_s;
               w_out_s = rd_w_s;
               last_s  = (rd_idx_s == AW'(N_INPUTS - 1));
               valid_s = 1'b1;
               busy_s  = 1'b1;
            end else begin
               valid_s = 1'b1;
               busy_s  = 1'b1;
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
            index_s = {AW{1'b0}};
         end
      endcase
   end

   // State, output and buffer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         index_r <= {AW{1'b0}};
         x_out_r <= {DATA_W{1'b0}};
         w_out_r <= {DATA_W{1'b0}};
         bias_r  <= {DATA_W{1'b0}};
         valid_r <= 1'b0;
         last_r  <= 1'b0;
         clear_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         for (int i = 0; i < N_INPUTS; i++) begin
            buf_x_r[i] <= {DATA_W{1'b0}};
            buf_w_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         state_r <= state_s;
         index_r <= index_s;
         x_out_r <= x_out_s;
         w_out_r <= w_out_s;
         bias_r  <= bias_s;
         valid_r <= valid_s;
         last_r  <= last_s;
         clear_r <= clear_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         for (int i = 0; i < N_INPUTS; i++) begin
            if (wr_hit_s && (bus.wr_addr == AW'(i))) begin
               buf_x_r[i] <= bus.wr_x;
               buf_w_r[i] <= bus.wr_w;
            end
         end
      end
   end

   assign bus.x_out     = x_out_r;
   assign bus.w_out     = w_out_r;
   assign bus.out_valid = valid_r;
   assign bus.out_last  = last_r;
   assign bus.acc_clear = clear_r;
   assign bus.bias_out  = bias_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
endmodule

// File: tb/tb_neuron_input_sequencer.sv
// Directed bench: a 3-entry sequencer for the main scenarios and a 1-entry
// sequencer for the single-pair corner case.
module tb_neuron_input_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   neuron_input_sequencer_if #(.N_INPUTS(3), .DATA_W(8)) ia ();
   neuron_input_sequencer_if #(.N_INPUTS(1), .DATA_W(8)) ib ();

   neuron_input_sequencer #(.N_INPUTS(3), .DATA_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   neuron_input_sequencer #(.N_INPUTS(1), .DATA_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_a(input int addr, input int x, input int w);
      ia.wr_en   = 1'b1;
      ia.wr_addr = 3'(addr);
      ia.wr_x    = 8'(x);
      ia.wr_w    = 8'(w);
      tick();
      ia.wr_en   = 1'b0;
   endtask

   task automatic pair_a(input string tag, input int x, input int w, input int last);
      chk({tag, "_valid"}, ia.out_valid, 1);
      chk({tag, "_x"}, $signed(ia.x_out), x);
      chk({tag, "_w"}, $signed(ia.w_out), w);
      chk({tag, "_last"}, ia.out_last, last);
   endtask

   initial begin
      rst = 1'b1;
      ia.wr_en = 1'b0; ia.wr_addr = 3'd0; ia.wr_x = 8'd0; ia.wr_w = 8'd0;
      ia.start = 1'b0; ia.bias_in = 8'd0; ia.out_ready = 1'b0;
      ib.wr_en = 1'b0; ib.wr_addr = 1'd0; ib.wr_x = 8'd0; ib.wr_w = 8'd0;
      ib.start = 1'b0; ib.bias_in = 8'd0; ib.out_ready = 1'b0;
      #3;
      chk("rst_busy", ia.busy, 0);
      chk("rst_valid", ia.out_valid, 0);
      chk("rst_bias", ia.bias_out, 0);
      chk("rst_done", ia.done, 0);
      tick();
      tick();
      rst = 1'b0;

      // Scenario 1: load and stream one pass with out_ready high
      write_a(0, 2, 5);
      write_a(1, -3, 6);
      write_a(2, 4, -7);
      ia.bias_in = 8'(-10); ia.start = 1'b1; ia.out_ready = 1'b1;
      tick();
      ia.start = 1'b0; ia.bias_in = 8'd0;
      chk("s1_clear", ia.acc_clear, 1);
      chk("s1_clear_valid", ia.out_valid, 0);
      chk("s1_clear_busy", ia.busy, 1);
      chk("s1_bias", $signed(ia.bias_out), -10);
      tick();
      pair_a("s1_p0", 2, 5, 0);
      chk("s1_clear_once", ia.acc_clear, 0);
      tick();
      pair_a("s1_p1", -3, 6, 0);
      tick();
      pair_a("s1_p2", 4, -7, 1);
      chk("s1_nodone_early", ia.done, 0);
      tick();
      chk("s1_done", ia.done, 1);
      chk("s1_done_valid", ia.out_valid, 0);
      chk("s1_done_busy", ia.busy, 0);
      tick();
      chk("s1_done_pulse", ia.done, 0);
      chk("s1_bias_hold", $signed(ia.bias_out), -10);

      // Scenario 2: back-pressure on pair 1
      ia.bias_in = 8'd7; ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      tick();
      pair_a("s2_p0", 2, 5, 0);
      tick();
      pair_a("s2_p1a", -3, 6, 0);
      ia.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         pair_a("s2_p1_hold", -3, 6, 0);
      end
      ia.out_ready = 1'b1;
      tick();
      pair_a("s2_p2", 4, -7, 1);
      tick();
      chk("s2_done", ia.done, 1);
      tick();
      chk("s2_idle", ia.busy, 0);
      chk("s2_bias", ia.bias_out, 7);

      // Scenario 3: writes during CLEAR/STREAM are ignored
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      ia.wr_en = 1'b1; ia.wr_addr = 3'd0; ia.wr_x = 8'd99; ia.wr_w = 8'd1;
      tick();
      pair_a("s3_p0", 2, 5, 0);
      tick();
      ia.wr_en = 1'b0;
      pair_a("s3_p1", -3, 6, 0);
      tick();
      tick();
      chk("s3_done", ia.done, 1);
      tick();

      // Scenario 3/4: second pass keeps original data; start while busy is ignored
      ia.start = 1'b1;
      tick();
      chk("s4_clear", ia.acc_clear, 1);
      tick();
      pair_a("s3_replay_p0", 2, 5, 0);
      chk("s4_no_clear_a", ia.acc_clear, 0);
      tick();
      ia.start = 1'b0;
      pair_a("s4_p1", -3, 6, 0);
      chk("s4_no_clear_b", ia.acc_clear, 0);
      tick();
      pair_a("s4_p2", 4, -7, 1);
      tick();
      chk("s4_done", ia.done, 1);
      tick();
      chk("s4_single_done", ia.done, 0);
      chk("s4_no_requeue_clear", ia.acc_clear, 0);
      tick();
      chk("s4_idle_busy", ia.busy, 0);
      chk("s4_idle_done", ia.done, 0);

      // Scenario 5: asynchronous reset mid-pass at index 1
      ia.bias_in = 8'(-1); ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      tick();
      tick();
      pair_a("s5_pre_p1", -3, 6, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("s5_rst_valid", ia.out_valid, 0);
      chk("s5_rst_x", ia.x_out, 0);
      chk("s5_rst_w", ia.w_out, 0);
      chk("s5_rst_busy", ia.busy, 0);
      chk("s5_rst_bias", ia.bias_out, 0);
      tick();
      chk("s5_rst_nodone", ia.done, 0);
      rst = 1'b0;
      tick();
      chk("s5_post_nodone", ia.done, 0);
      ia.bias_in = 8'd3; ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      chk("s5_clear", ia.acc_clear, 1);
      chk("s5_bias", ia.bias_out, 3);
      tick();
      pair_a("s5_p0", 0, 0, 0);
      tick();
      pair_a("s5_p1", 0, 0, 0);
      tick();
      pair_a("s5_p2", 0, 0, 1);
      tick();
      chk("s5_done", ia.done, 1);

      // Scenario 6: single-entry build, write and start in the same cycle
      ib.wr_en = 1'b1; ib.wr_addr = 1'd0; ib.wr_x = 8'h80; ib.wr_w = 8'h7F;
      ib.start = 1'b1; ib.out_ready = 1'b1; ib.bias_in = 8'd5;
      tick();
      ib.wr_en = 1'b0; ib.start = 1'b0;
      chk("s6_clear", ib.acc_clear, 1);
      tick();
      chk("s6_valid", ib.out_valid, 1);
      chk("s6_last", ib.out_last, 1);
      chk("s6_x", $signed(ib.x_out), -128);
      chk("s6_w", $signed(ib.w_out), 127);
      tick();
      chk("s6_done", ib.done, 1);
      chk("s6_done_valid", ib.out_valid, 0);
      tick();
      chk("s6_done_pulse", ib.done, 0);
      chk("s6_bias", ib.bias_out, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
